// File: rtl/clock_set_if.sv
// Bundle between the time-setting controller and the buttons/counter chain.
// The controller takes the slave view; whoever drives buttons and live time takes master.
interface clock_set_if #(
    parameter int HOURS_MAX   = 24,
    parameter int MINUTES_MAX = 60
);
    localparam int HW = $clog2(HOURS_MAX) + 1;
    localparam int MW = $clog2(MINUTES_MAX) + 1;

    logic          sec_tick;
    logic          btn_mode;
    logic          btn_inc;
    logic          btn_dec;
    logic [HW-1:0] cur_hours;
    logic [MW-1:0] cur_minutes;
    logic          run_en;
    logic          load_hours;
    logic          load_minutes;
    logic          load_seconds;
    logic [HW-1:0] hours_value;
    logic [MW-1:0] minutes_value;
    logic          blink_hours;
    logic          blink_minutes;
    logic [1:0]    state_o;

    modport slave (
        input  sec_tick, btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
        output run_en, load_hours, load_minutes, load_seconds,
               hours_value, minutes_value, blink_hours, blink_minutes, state_o
    );

    modport master (
        output sec_tick, btn_mode, btn_inc, btn_dec, cur_hours, cur_minutes,
        input  run_en, load_hours, load_minutes, load_seconds,
               hours_value, minutes_value, blink_hours, blink_minutes, state_o
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: walks RUN -> SET_H -> SET_M -> COMMIT, edits shadow
// hour/minute values and loads them into the counter chain in one commit cycle.
module clock_set_ctrl #(
    parameter int HOURS_MAX   = 24,
    parameter int MINUTES_MAX = 60,
    parameter int TIMEOUT_SEC = 10
) (
    input  logic        clk,
    input  logic        rst,
    clock_set_if.slave  bus
);
    localparam int HW = $clog2(HOURS_MAX) + 1;
    localparam int MW = $clog2(MINUTES_MAX) + 1;
    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        SET_H  = 2'b01,
        SET_M  = 2'b10,
        COMMIT = 2'b11
    } state_t;

    state_t        state;
    logic [TW-1:0] idle_cnt;
    logic [HW-1:0] shadow_h;
    logic [MW-1:0] shadow_m;
    logic          run_en;
    logic          load;
    logic          blink_h;
    logic          blink_m;

    function automatic logic [HW-1:0] step_hours(input logic [HW-1:0] v, input logic up);
        if (up) return (v == HW'(HOURS_MAX - 1)) ? '0 : v + 1'b1;
        return (v == '0) ? HW'(HOURS_MAX - 1) : v - 1'b1;
    endfunction

    function automatic logic [MW-1:0] step_minutes(input logic [MW-1:0] v, input logic up);
        if (up) return (v == MW'(MINUTES_MAX - 1)) ? '0 : v + 1'b1;
        return (v == '0) ? MW'(MINUTES_MAX - 1) : v - 1'b1;
    endfunction

    // inc and dec together count as activity but cancel each other out
    logic btn_any;
    logic adjust;
    logic timed_out;
    assign btn_any   = bus.btn_inc | bus.btn_dec;
    assign adjust    = bus.btn_inc ^ bus.btn_dec;
    assign timed_out = bus.sec_tick && (idle_cnt == TW'(TIMEOUT_SEC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            idle_cnt <= '0;
            shadow_h <= '0;
            shadow_m <= '0;
            run_en   <= 1'b1;
            load     <= 1'b0;
            blink_h  <= 1'b0;
            blink_m  <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                RUN: begin
                    run_en  <= 1'b1;
                    blink_h <= 1'b0;
                    blink_m <= 1'b0;
                    if (bus.btn_mode) begin
                        state    <= SET_H;
                        run_en   <= 1'b0;
                        shadow_h <= bus.cur_hours;
                        shadow_m <= bus.cur_minutes;
                        idle_cnt <= '0;
                    end
                end
                SET_H: begin
                    blink_m <= 1'b0;
                    if (bus.btn_mode) begin
                        state    <= SET_M;
                        blink_h  <= 1'b0;
                        idle_cnt <= '0;
                    end else if (btn_any) begin
                        idle_cnt <= '0;
                        if (adjust) shadow_h <= step_hours(shadow_h, bus.btn_inc);
                        if (bus.sec_tick) blink_h <= ~blink_h;
                    end else if (timed_out) begin
                        state    <= RUN;
                        run_en   <= 1'b1;
                        blink_h  <= 1'b0;
                        idle_cnt <= '0;
                    end else if (bus.sec_tick) begin
                        idle_cnt <= idle_cnt + 1'b1;
                        blink_h  <= ~blink_h;
                    end
                end
                SET_M: begin
                    blink_h <= 1'b0;
                    if (bus.btn_mode) begin
                        state    <= COMMIT;
                        load     <= 1'b1;
                        blink_m  <= 1'b0;
                        idle_cnt <= '0;
                    end else if (btn_any) begin
                        idle_cnt <= '0;
                        if (adjust) shadow_m <= step_minutes(shadow_m, bus.btn_inc);
                        if (bus.sec_tick) blink_m <= ~blink_m;
                    end else if (timed_out) begin
                        state    <= RUN;
                        run_en   <= 1'b1;
                        blink_m  <= 1'b0;
                        idle_cnt <= '0;
                    end else if (bus.sec_tick) begin
                        idle_cnt <= idle_cnt + 1'b1;
                        blink_m  <= ~blink_m;
                    end
                end
                COMMIT: begin
                    state  <= RUN;
                    run_en <= 1'b1;
                end
            endcase
        end
    end

    // The seconds counter is fed zero externally, so one strobe serves all three loads
    assign bus.run_en        = run_en;
    assign bus.load_hours    = load;
    assign bus.load_minutes  = load;
    assign bus.load_seconds  = load;
    assign bus.hours_value   = shadow_h;
    assign bus.minutes_value = shadow_m;
    assign bus.blink_hours   = blink_h;
    assign bus.blink_minutes = blink_m;
    assign bus.state_o       = state;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: commit path, wrap-around, timeout,
// same-cycle button priority and asynchronous reset while setting.
module tb_clock_set_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    clock_set_if #(.HOURS_MAX(24), .MINUTES_MAX(60)) bus ();

    clock_set_ctrl #(.HOURS_MAX(24), .MINUTES_MAX(60), .TIMEOUT_SEC(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one clock with the given pulses applied; returns 1 time unit after the edge
    task automatic cyc(input logic m, input logic i, input logic d, input logic t);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        bus.btn_dec  = d;
        bus.sec_tick = t;
        @(posedge clk);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        bus.sec_tick = 1'b0;
    endtask

    function automatic logic [2:0] loads();
        return {bus.load_hours, bus.load_minutes, bus.load_seconds};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        bus.sec_tick = 1'b0;
        bus.cur_hours   = 6'd0;
        bus.cur_minutes = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        chk("reset_state", bus.state_o, 0);
        chk("reset_run_en", bus.run_en, 1);
        chk("reset_loads", loads(), 0);
        chk("reset_shadow_h", bus.hours_value, 0);
        chk("reset_shadow_m", bus.minutes_value, 0);
        chk("reset_blink", {bus.blink_hours, bus.blink_minutes}, 0);
        for (int k = 0; k < 100; k++) begin
            cyc(0, 0, 0, k[0]);
            chk("idle_run", {bus.state_o, bus.run_en, loads()}, 6'b00_1_000);
        end

        // 13:45 -> 16:55
        bus.cur_hours   = 6'd13;
        bus.cur_minutes = 7'd45;
        cyc(1, 0, 0, 0);
        chk("seth_state", bus.state_o, 1);
        chk("seth_run_en", bus.run_en, 0);
        chk("seth_capture_h", bus.hours_value, 13);
        chk("seth_capture_m", bus.minutes_value, 45);
        repeat (3) cyc(0, 1, 0, 0);
        chk("inc3_h", bus.hours_value, 16);
        cyc(1, 0, 0, 0);
        chk("setm_state", bus.state_o, 2);
        repeat (50) cyc(0, 0, 1, 0);
        chk("dec50_m", bus.minutes_value, 55);
        chk("dec50_h_kept", bus.hours_value, 16);
        cyc(1, 0, 0, 0);
        chk("commit_state", bus.state_o, 3);
        chk("commit_loads", loads(), 3'b111);
        chk("commit_run_en", bus.run_en, 0);
        chk("commit_h", bus.hours_value, 16);
        chk("commit_m", bus.minutes_value, 55);
        cyc(0, 0, 0, 0);
        chk("post_commit", {bus.state_o, bus.run_en, loads()}, 6'b00_1_000);

        // wrap: 23:00 -> 00:59
        bus.cur_hours   = 6'd23;
        bus.cur_minutes = 7'd0;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("wrap_h_up", bus.hours_value, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("wrap_m_down", bus.minutes_value, 59);
        cyc(1, 0, 0, 0);
        chk("wrap_commit_loads", loads(), 3'b111);
        chk("wrap_commit_val", {bus.hours_value, bus.minutes_value}, {6'd0, 7'd59});
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("run_inc_ignored", {bus.state_o, bus.hours_value}, {2'd0, 6'd0});

        // timeout with restart on the 9th tick
        bus.cur_hours   = 6'd5;
        bus.cur_minutes = 7'd10;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("blink_h_on", {bus.blink_hours, bus.blink_minutes}, 2'b10);
        repeat (7) cyc(0, 0, 0, 1);
        chk("to_8_ticks", bus.state_o, 1);
        cyc(0, 1, 0, 1);
        chk("to_inc_9th", {bus.state_o, bus.hours_value}, {2'd1, 6'd6});
        repeat (9) cyc(0, 0, 0, 1);
        chk("to_restart_9", bus.state_o, 1);
        cyc(0, 0, 0, 1);
        chk("to_abort_state", bus.state_o, 0);
        chk("to_abort_run_en", bus.run_en, 1);
        chk("to_abort_loads", loads(), 0);
        chk("to_abort_blink", {bus.blink_hours, bus.blink_minutes}, 0);
        cyc(0, 0, 0, 0);
        chk("to_after_loads", loads(), 0);

        // button on the final tick, inc+dec, mode+inc
        bus.cur_hours   = 6'd7;
        bus.cur_minutes = 7'd30;
        cyc(1, 0, 0, 0);
        repeat (9) cyc(0, 0, 0, 1);
        cyc(0, 1, 1, 1);
        chk("incdec_final_tick", {bus.state_o, bus.hours_value}, {2'd1, 6'd7});
        repeat (9) cyc(0, 0, 0, 1);
        chk("incdec_restarted", bus.state_o, 1);
        cyc(1, 1, 0, 0);
        chk("mode_inc_state", {bus.state_o, bus.hours_value}, {2'd2, 6'd7});
        cyc(0, 1, 0, 0);
        chk("setm_inc", bus.minutes_value, 31);
        cyc(0, 0, 0, 1);
        chk("blink_m_on", {bus.blink_hours, bus.blink_minutes}, 2'b01);

        // asynchronous reset in SET_M
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", {bus.state_o, bus.run_en, loads()}, 6'b00_1_000);
        chk("async_rst_shadow", {bus.hours_value, bus.minutes_value}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        chk("after_rst_loads", {bus.state_o, loads()}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
